// File: rtl/ex_stage_pkg.sv
// Execute-stage output bundle consumed by the memory-access stage.
package ex_stage_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] opr_b;
        logic [31:0] opr_res;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
    } ex_stage_out_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Types shared by the memory-access stage: writeback bundle, FSM state and wb_sel load encoding.
package mem_stage_pkg;

    import ex_stage_pkg::*;

    localparam logic [1:0] WB_SEL_MEM_DEFAULT = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] opr_res;
        logic [31:0] rdata;
        logic        rf_en;
        logic [1:0]  wb_sel;
        logic        misalign;
    } mem_stage_out_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store at a time and hands results to writeback.
// Optional MEM_STAGE_MISALIGN_CHECK_EN flags misaligned accesses instead of issuing them.
//
// state | meaning
// IDLE  | empty, ready for an instruction from execute
// REQ   | request held on the memory port until granted
// WAIT  | load granted, waiting for read data
// DONE  | result presented to writeback until accepted
module mem_stage
    import ex_stage_pkg::*;
    import mem_stage_pkg::*;
#(
    parameter logic [1:0] WB_SEL_MEM = WB_SEL_MEM_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  ex_stage_out_t  ex_i,
    input  logic           ex_valid_i,
    output logic           ex_ready_o,
    output logic           dm_req_o,
    output logic           dm_we_o,
    output logic [31:0]    dm_addr_o,
    output logic [31:0]    dm_wdata_o,
    input  logic           dm_gnt_i,
    input  logic           dm_rvalid_i,
    input  logic [31:0]    dm_rdata_i,
    output mem_stage_out_t wb_o,
    output logic           wb_valid_o,
    input  logic           wb_ready_i
);

    mem_state_t    state_q, state_d;
    ex_stage_out_t hold_q, hold_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ex_ready;
    logic          is_mem_in;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic          mis_q, mis_d;
`endif

    assign is_mem_in = ex_i.dm_en || (ex_i.wb_sel == WB_SEL_MEM);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        ex_ready = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            IDLE: ex_ready = 1'b1;
            REQ: begin
                if (dm_gnt_i) begin
                    if (hold_q.dm_en) begin
                        state_d = DONE;
                    end else if (dm_rvalid_i) begin
                        rdata_d = dm_rdata_i;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dm_rvalid_i) begin
                    rdata_d = dm_rdata_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                ex_ready = wb_ready_i;
                if (wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the DONE->IDLE step so instructions can stream back-to-back.
        if (ex_valid_i && ex_ready) begin
            hold_d  = ex_i;
            rdata_d = '0;
            state_d = is_mem_in ? REQ : DONE;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            mis_d = is_mem_in && (ex_i.opr_res[1:0] != 2'b00);
            if (mis_d) state_d = DONE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rdata_q <= '0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign ex_ready_o = ex_ready;
    assign dm_req_o   = (state_q == REQ);
    assign dm_we_o    = dm_req_o && hold_q.dm_en;
    assign dm_addr_o  = dm_req_o ? {hold_q.opr_res[31:2], 2'b00} : '0;
    assign dm_wdata_o = dm_we_o ? hold_q.opr_b : '0;
    assign wb_valid_o = (state_q == DONE);

    always_comb begin
        wb_o         = '0;
        wb_o.rd      = hold_q.rd;
        wb_o.opr_res = hold_q.opr_res;
        wb_o.rdata   = rdata_q;
        wb_o.wb_sel  = hold_q.wb_sel;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        wb_o.rf_en    = hold_q.rf_en && !mis_q;
        wb_o.misalign = mis_q;
`else
        wb_o.rf_en    = hold_q.rf_en;
        wb_o.misalign = 1'b0;
`endif
    end

endmodule
